common_regs_v2: RTL

//  Common register bank behind the AXI4-Lite slave front-end. It holds the build date/time ID,
//  a parameter-info word, NUM_SCRATCH byte-strobed scratch registers, an inverting test register
//  and a 64-bit uptime counter with atomic hi/lo snapshot. All logic is synchronous to
//  S_AXI_ACLK; rd/wr strobes are sampled on the clock, never used as clocks.

---
 rtl/common_regs_pkg.sv | 38 +++
 rtl/common_uptime_ctr.sv | 37 +++
 rtl/common_regs_v2.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/common_regs_pkg.sv
// rtl/common_regs_pkg.sv - Shared offsets, ID constants and byte-strobe helper for common_regs_v2.
`ifndef COMPILE_DATE
`define COMPILE_DATE 32'h2024_0601
`endif
`ifndef COMPILE_TIME
`define COMPILE_TIME 32'h0012_3000
`endif

package common_regs_pkg;

    localparam logic [7:0] OFS_DATE      = 8'h00;
    localparam logic [7:0] OFS_TIME      = 8'h04;
    localparam logic [7:0] OFS_INFO      = 8'h08;
    localparam logic [7:0] OFS_CTRL      = 8'h0C;
    localparam logic [7:0] OFS_UPTIME_LO = 8'h10;
    localparam logic [7:0] OFS_UPTIME_HI = 8'h14;
    localparam logic [7:0] OFS_INV       = 8'h18;
    localparam logic [7:0] OFS_SCRATCH0  = 8'h40;

    localparam logic [7:0] INFO_ID = 8'hC2;

    localparam int CTRL_FREEZE_BIT = 0;
    localparam int CTRL_CLEAR_BIT  = 1;

    localparam int MAX_SCRATCH = 16;

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/common_uptime_ctr.sv
// rtl/common_uptime_ctr.sv - 64-bit uptime counter with freeze, clear and hi-word snapshot on lo read.
module common_uptime_ctr (
    input  logic        clk_i,
    input  logic        aresetn_i,
    input  logic        freeze_i,
    input  logic        clear_i,
    input  logic        lo_rd_i,
    output logic [31:0] cnt_lo_o,
    output logic [31:0] hi_shadow_o
);

    logic [63:0] cnt_q, cnt_d;
    logic [31:0] shadow_q, shadow_d;

    // Clear wins over increment; the snapshot uses the pre-update count so
    // a lo read coincident with clear still sees a coherent 64-bit value.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i)        cnt_d = 64'd0;
        else if (!freeze_i) cnt_d = cnt_q + 64'd1;
        shadow_d = lo_rd_i ? cnt_q[63:32] : shadow_q;
    end

    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            cnt_q    <= 64'd0;
            shadow_q <= 32'd0;
        end else begin
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
        end
    end

    assign cnt_lo_o    = cnt_q[31:0];
    assign hi_shadow_o = shadow_q;

endmodule

// File: rtl/common_regs_v2.sv
// rtl/common_regs_v2.sv - Common register bank (ID, info, scratch, inverting test, uptime).
// Optional uptime counter and CTRL register enabled by defining COMMON_REGS_UPTIME_EN.
module common_regs_v2
    import common_regs_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 12,
    parameter int NUM_SCRATCH        = 4
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic [31:0]                   S_AXI_WDATA,
    input  logic [3:0]                    S_AXI_WSTRB,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic                          common_reg_wren,
    input  logic                          common_reg_rden,
    output logic [31:0]                   common_reg_data,
    output logic                          common_reg_rvalid,
    output logic                          common_reg_err
);

    if (C_S_AXI_DATA_WIDTH != 32) begin : g_bad_dw
        $error("common_regs_v2: only C_S_AXI_DATA_WIDTH=32 is supported");
    end
    if (C_S_AXI_ADDR_WIDTH < 9) begin : g_bad_aw
        $error("common_regs_v2: C_S_AXI_ADDR_WIDTH must be at least 9");
    end
    if (NUM_SCRATCH < 1 || NUM_SCRATCH > MAX_SCRATCH) begin : g_bad_ns
        $error("common_regs_v2: NUM_SCRATCH must be 1..16");
    end

`ifdef COMMON_REGS_UPTIME_EN
    localparam logic UPTIME_EN_BIT = 1'b1;
`else
    localparam logic UPTIME_EN_BIT = 1'b0;
`endif

    logic        unused_addr;
    assign unused_addr = ^{S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:8], S_AXI_AWADDR[1:0],
                           S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:8], S_AXI_ARADDR[1:0]};

    logic [7:0]  wr_ofs, rd_ofs;
    logic [3:0]  wr_sidx, rd_sidx;
    logic        wr_shit, rd_shit;

    assign wr_ofs  = {S_AXI_AWADDR[7:2], 2'b00};
    assign rd_ofs  = {S_AXI_ARADDR[7:2], 2'b00};
    assign wr_sidx = S_AXI_AWADDR[5:2];
    assign rd_sidx = S_AXI_ARADDR[5:2];
    // Scratch window is word indices 16..31; only the first NUM_SCRATCH exist.
    assign wr_shit = (S_AXI_AWADDR[7:6] == 2'b01) && ({1'b0, wr_sidx} < 5'(NUM_SCRATCH));
    assign rd_shit = (S_AXI_ARADDR[7:6] == 2'b01) && ({1'b0, rd_sidx} < 5'(NUM_SCRATCH));

    logic [31:0] scratch_q [NUM_SCRATCH];
    logic [31:0] scratch_d [NUM_SCRATCH];
    logic [31:0] inv_q, inv_d;
    logic [31:0] rdata_q, rd_data_d;
    logic        rvalid_q, err_q;
    logic        wr_bad, rd_bad;

`ifdef COMMON_REGS_UPTIME_EN
    logic        freeze_q, freeze_d;
    logic        clear_pulse;
    logic [31:0] up_lo, up_hi;

    common_uptime_ctr u_uptime (
        .clk_i      (S_AXI_ACLK),
        .aresetn_i  (S_AXI_ARESETN),
        .freeze_i   (freeze_q),
        .clear_i    (clear_pulse),
        .lo_rd_i    (common_reg_rden && (rd_ofs == OFS_UPTIME_LO)),
        .cnt_lo_o   (up_lo),
        .hi_shadow_o(up_hi)
    );
`endif

    always_comb begin
        scratch_d = scratch_q;
        inv_d     = inv_q;
        wr_bad    = 1'b0;
`ifdef COMMON_REGS_UPTIME_EN
        freeze_d    = freeze_q;
        clear_pulse = 1'b0;
`endif
        if (common_reg_wren) begin
            if (wr_shit) begin
                for (int i = 0; i < NUM_SCRATCH; i++) begin
                    if (wr_sidx == 4'(i))
                        scratch_d[i] = apply_wstrb(scratch_q[i], S_AXI_WDATA, S_AXI_WSTRB);
                end
            end else begin
                case (wr_ofs)
                    OFS_INV: inv_d = apply_wstrb(inv_q, S_AXI_WDATA, S_AXI_WSTRB);
`ifdef COMMON_REGS_UPTIME_EN
                    OFS_CTRL: begin
                        if (S_AXI_WSTRB[0]) begin
                            freeze_d    = S_AXI_WDATA[CTRL_FREEZE_BIT];
                            clear_pulse = S_AXI_WDATA[CTRL_CLEAR_BIT];
                        end
                    end
`endif
                    default: wr_bad = 1'b1;
                endcase
            end
        end
    end

    always_comb begin
        rd_data_d = 32'd0;
        rd_bad    = 1'b0;
        if (rd_shit) begin
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                if (rd_sidx == 4'(i)) rd_data_d = scratch_q[i];
            end
        end else begin
            case (rd_ofs)
                OFS_DATE:      rd_data_d = 32'(`COMPILE_DATE);
                OFS_TIME:      rd_data_d = 32'(`COMPILE_TIME);
                OFS_INFO:      rd_data_d = {INFO_ID, 7'd0, UPTIME_EN_BIT, 8'd0, 8'(NUM_SCRATCH)};
                OFS_INV:       rd_data_d = ~inv_q;
`ifdef COMMON_REGS_UPTIME_EN
                OFS_CTRL:      rd_data_d = {31'd0, freeze_q};
                OFS_UPTIME_LO: rd_data_d = up_lo;
                OFS_UPTIME_HI: rd_data_d = up_hi;
`endif
                default:       rd_bad = 1'b1;
            endcase
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            for (int i = 0; i < NUM_SCRATCH; i++) scratch_q[i] <= 32'd0;
            inv_q    <= 32'd0;
            rdata_q  <= 32'd0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
`ifdef COMMON_REGS_UPTIME_EN
            freeze_q <= 1'b0;
`endif
        end else begin
            scratch_q <= scratch_d;
            inv_q     <= inv_d;
            rvalid_q  <= common_reg_rden;
            err_q     <= (common_reg_rden && rd_bad) || (common_reg_wren && wr_bad);
            if (common_reg_rden) rdata_q <= rd_data_d;
`ifdef COMMON_REGS_UPTIME_EN
            freeze_q  <= freeze_d;
`endif
        end
    end

    assign common_reg_data   = rdata_q;
    assign common_reg_rvalid = rvalid_q;
    assign common_reg_err    = err_q;

endmodule
